// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
//
// Produces PC / IF-ID write enables and IF-ID / ID-EX bubble controls for
// load-use, branch/jr operand dependencies, taken-branch redirect and the
// multi-cycle MULT/DIV unit. It also sequences that unit. It does not select
// operand data; forwarding in EX does that.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   id/id_ex/ex_mem_instruction   instructions in ID / EX / MEM
//   id_ex_gpr_w_sel, ex_mem_gpr_w_sel  destination select (GPR_* encoding)
//   id_ex_mem_read, ex_mem_mem_read    stage holds a load
//   id_uses_rs, id_uses_rt   ID instruction reads rs / rt
//   id_is_branch, id_branch_taken      ID branch/jr and its resolution
//   id_is_md, id_md_is_div   ID holds MULT/MULTU/DIV/DIVU
//   id_reads_hilo            ID holds MFHI/MFLO
//   pc_write, if_id_write    update enables
//   if_id_flush, id_ex_flush bubble controls
//   md_start, md_busy        MULT/DIV unit start pulse / occupancy
//
// state | meaning
// IDLE  | MULT/DIV unit free, may accept a new operation
// BUSY  | operation in flight, cnt counts down the remaining cycles
// DONE  | final cycle, unit writes HI/LO

`ifndef GPR_NONE
`define GPR_NONE 2'd0
`endif
`ifndef GPR_RT
`define GPR_RT 2'd1
`endif
`ifndef GPR_RD
`define GPR_RD 2'd2
`endif
`ifndef GPR_RA
`define GPR_RA 2'd3
`endif

module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instruction,
  input  logic [31:0] id_ex_instruction,
  input  logic [31:0] ex_mem_instruction,
  input  logic [1:0]  id_ex_gpr_w_sel,
  input  logic [1:0]  ex_mem_gpr_w_sel,
  input  logic        id_ex_mem_read,
  input  logic        ex_mem_mem_read,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_branch_taken,
  input  logic        id_is_md,
  input  logic        id_md_is_div,
  input  logic        id_reads_hilo,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        md_start,
  output logic        md_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       hit_ex, hit_mem;
  logic       load_use, br_ex, br_load_mem, md_hazard, stall;

  // Only the register fields of the instructions are examined.
  logic unused_bits;
  assign unused_bits = ^{id_instruction[31:26], id_instruction[15:0],
                         id_ex_instruction[31:21], id_ex_instruction[10:0],
                         ex_mem_instruction[31:21], ex_mem_instruction[10:0]};

  function automatic logic [4:0] dest_reg(input logic [31:0] instr,
                                          input logic [1:0]  sel);
    logic [4:0] r;
    r = 5'd0;
    case (sel)
      `GPR_RT: r = instr[20:16];
      `GPR_RD: r = instr[15:11];
      `GPR_RA: r = 5'd31;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign id_rs   = id_instruction[25:21];
  assign id_rt   = id_instruction[20:16];
  assign ex_dst  = dest_reg(id_ex_instruction, id_ex_gpr_w_sel);
  assign mem_dst = dest_reg(ex_mem_instruction, ex_mem_gpr_w_sel);

  // $0 as a destination (including GPR_NONE) never produces a hazard.
  assign hit_ex  = (ex_dst != 5'd0) &&
                   ((id_uses_rs && ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
  assign hit_mem = (mem_dst != 5'd0) &&
                   ((id_uses_rs && mem_dst == id_rs) || (id_uses_rt && mem_dst == id_rt));

  assign load_use    = id_ex_mem_read & hit_ex;
  assign br_ex       = id_is_branch & hit_ex;
  assign br_load_mem = id_is_branch & ex_mem_mem_read & hit_mem;
  assign md_hazard   = (id_reads_hilo | id_is_md) & (state_q != IDLE);
  assign stall       = load_use | br_ex | br_load_mem | md_hazard;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_start    = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    md_busy     = (state_q != IDLE);

    if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_branch_taken) begin
      if_id_flush = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Gated by rst so no start pulse escapes while reset is held.
        if (id_is_md && !stall && rst) begin
          md_start = 1'b1;
          state_d  = BUSY;
          cnt_d    = id_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd1) begin
          state_d = DONE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl with a cycle-level reference
// model: the MULT/DIV unit is modelled as a "cycles remaining" count.
module tb_hazard_ctrl;

  localparam int MC = 4;
  localparam int DC = 32;
  localparam logic [1:0] S_NONE = 2'd0, S_RT = 2'd1, S_RD = 2'd2, S_RA = 2'd3;

  logic        clk, rst;
  logic [31:0] id_instruction, id_ex_instruction, ex_mem_instruction;
  logic [1:0]  id_ex_gpr_w_sel, ex_mem_gpr_w_sel;
  logic        id_ex_mem_read, ex_mem_mem_read, id_uses_rs, id_uses_rt;
  logic        id_is_branch, id_branch_taken, id_is_md, id_md_is_div, id_reads_hilo;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_busy;

  hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .id_instruction(id_instruction), .id_ex_instruction(id_ex_instruction),
    .ex_mem_instruction(ex_mem_instruction),
    .id_ex_gpr_w_sel(id_ex_gpr_w_sel), .ex_mem_gpr_w_sel(ex_mem_gpr_w_sel),
    .id_ex_mem_read(id_ex_mem_read), .ex_mem_mem_read(ex_mem_mem_read),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .id_is_md(id_is_md), .id_md_is_div(id_md_is_div), .id_reads_hilo(id_reads_hilo),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .md_start(md_start), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int md_left  = 0;  // cycles the MULT/DIV unit remains occupied
  logic o_pc, o_ifw, o_ifid, o_idex, o_start, o_busy;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic int dst_of(input logic [31:0] i, input logic [1:0] sel);
    if (sel == S_RT) return int'(i[20:16]);
    if (sel == S_RD) return int'(i[15:11]);
    if (sel == S_RA) return 31;
    return 0;
  endfunction

  function automatic bit depends(input int d);
    if (d == 0) return 0;
    return (id_uses_rs && d == int'(id_instruction[25:21])) ||
           (id_uses_rt && d == int'(id_instruction[20:16]));
  endfunction

  task automatic idle();
    id_instruction = '0; id_ex_instruction = '0; ex_mem_instruction = '0;
    id_ex_gpr_w_sel = S_NONE; ex_mem_gpr_w_sel = S_NONE;
    id_ex_mem_read = 0; ex_mem_mem_read = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_branch = 0; id_branch_taken = 0; id_is_md = 0; id_md_is_div = 0;
    id_reads_hilo = 0;
  endtask

  // One clock cycle: compare all outputs against the model, then advance.
  task automatic cyc();
    bit dep_ex, dep_mem, busy, st, e_start;
    #2;
    dep_ex  = depends(dst_of(id_ex_instruction, id_ex_gpr_w_sel));
    dep_mem = depends(dst_of(ex_mem_instruction, ex_mem_gpr_w_sel));
    busy    = (md_left != 0);
    st = (id_ex_mem_read && dep_ex) || (id_is_branch && dep_ex) ||
         (id_is_branch && ex_mem_mem_read && dep_mem) ||
         ((id_reads_hilo || id_is_md) && busy);
    e_start = rst && id_is_md && !st && !busy;
    o_pc = pc_write; o_ifw = if_id_write; o_ifid = if_id_flush;
    o_idex = id_ex_flush; o_start = md_start; o_busy = md_busy;
    chk("pc_write", o_pc, !st);
    chk("if_id_write", o_ifw, !st);
    chk("id_ex_flush", o_idex, st);
    chk("if_id_flush", o_ifid, !st && id_branch_taken);
    chk("md_start", o_start, e_start);
    chk("md_busy", o_busy, busy);
    @(posedge clk);
    if (!rst) md_left = 0;
    else if (e_start) md_left = id_md_is_div ? DC : MC;
    else if (md_left > 0) md_left--;
    #1;
  endtask

  initial begin
    int stalls, starts;
    bit found;
    idle();
    rst = 0;
    @(posedge clk); #1;
    cyc();
    rst = 1;
    cyc();
    chk("rst_pc", o_pc, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_flush", o_idex | o_ifid, 1'b0);

    // lw $2 in EX, add $3,$2,$4 in ID
    idle(); id_ex_instruction = ins(1, 2, 0); id_ex_gpr_w_sel = S_RT; id_ex_mem_read = 1;
    id_instruction = ins(2, 4, 3); id_uses_rs = 1; id_uses_rt = 1;
    cyc(); chk("lu_stall", o_pc, 1'b0); chk("lu_bubble", o_idex, 1'b1);
    id_ex_instruction = '0; id_ex_gpr_w_sel = S_NONE; id_ex_mem_read = 0;
    ex_mem_instruction = ins(1, 2, 0); ex_mem_gpr_w_sel = S_RT; ex_mem_mem_read = 1;
    cyc(); chk("lu_proceed", o_pc, 1'b1);
    idle(); id_ex_instruction = ins(1, 0, 0); id_ex_gpr_w_sel = S_RT; id_ex_mem_read = 1;
    id_instruction = ins(0, 4, 3); id_uses_rs = 1; id_uses_rt = 1;
    cyc(); chk("lu_r0", o_pc, 1'b1);

    // add $5 in EX, beq $5,$6
    idle(); id_ex_instruction = ins(1, 2, 5); id_ex_gpr_w_sel = S_RD;
    id_instruction = ins(5, 6, 0); id_uses_rs = 1; id_uses_rt = 1; id_is_branch = 1;
    cyc(); chk("br_ex", o_pc, 1'b0);
    ex_mem_instruction = id_ex_instruction; ex_mem_gpr_w_sel = S_RD;
    id_ex_instruction = '0; id_ex_gpr_w_sel = S_NONE;
    cyc(); chk("br_ex_release", o_pc, 1'b1);
    // lw $5 then beq $5: two stalls
    idle(); id_ex_instruction = ins(1, 5, 0); id_ex_gpr_w_sel = S_RT; id_ex_mem_read = 1;
    id_instruction = ins(5, 6, 0); id_uses_rs = 1; id_uses_rt = 1; id_is_branch = 1;
    cyc(); chk("lw_br_1", o_pc, 1'b0);
    ex_mem_instruction = id_ex_instruction; ex_mem_gpr_w_sel = S_RT; ex_mem_mem_read = 1;
    id_ex_instruction = '0; id_ex_gpr_w_sel = S_NONE; id_ex_mem_read = 0;
    cyc(); chk("lw_br_2", o_pc, 1'b0);
    ex_mem_instruction = '0; ex_mem_gpr_w_sel = S_NONE; ex_mem_mem_read = 0;
    cyc(); chk("lw_br_3", o_pc, 1'b1);
    // jal in EX, jr $31
    idle(); id_ex_gpr_w_sel = S_RA; id_instruction = ins(31, 0, 0);
    id_uses_rs = 1; id_is_branch = 1;
    cyc(); chk("jr_ra", o_pc, 1'b0);

    // taken branch, no dependency
    idle(); id_instruction = ins(7, 8, 0); id_uses_rs = 1; id_uses_rt = 1;
    id_is_branch = 1; id_branch_taken = 1;
    cyc(); chk("tk_flush", o_ifid, 1'b1); chk("tk_pc", o_pc, 1'b1);
    // taken branch behind a load it depends on via EX
    id_ex_instruction = ins(1, 7, 0); id_ex_gpr_w_sel = S_RT; id_ex_mem_read = 1;
    cyc(); chk("tk_stall_noflush", o_ifid, 1'b0);
    id_ex_instruction = '0; id_ex_gpr_w_sel = S_NONE; id_ex_mem_read = 0;
    cyc(); chk("tk_after_stall", o_ifid, 1'b1);

    // mult, unrelated addu, then mflo
    idle(); id_is_md = 1;
    cyc(); chk("mult_start", o_start, 1'b1);
    idle(); id_instruction = ins(1, 2, 3); id_uses_rs = 1; id_uses_rt = 1;
    cyc(); chk("addu_no_stall", o_pc, 1'b1); chk("addu_busy", o_busy, 1'b1);
    idle(); id_reads_hilo = 1; stalls = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (o_pc) found = 1; else stalls++;
    end
    chk("mflo_issue", found, 1'b1);
    chk("mflo_stalls3", stalls == 3, 1'b1);
    // mult then immediate mflo
    idle(); id_is_md = 1;
    cyc();
    idle(); id_reads_hilo = 1; stalls = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (o_pc) found = 1; else stalls++;
    end
    chk("mflo_stalls4", stalls == MC, 1'b1);

    // div then div
    idle(); id_is_md = 1; id_md_is_div = 1;
    cyc(); chk("div1_start", o_start, 1'b1);
    stalls = 0; found = 0; starts = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (o_start) begin found = 1; starts++; end
      else if (!o_pc) stalls++;
    end
    chk("div2_start", found, 1'b1);
    chk("div2_stalls", stalls == DC, 1'b1);
    chk("div2_once", starts == 1, 1'b1);

    // reset mid-BUSY
    idle(); repeat (21) cyc();
    rst = 0; cyc(); rst = 1;
    id_reads_hilo = 1;
    cyc(); chk("post_rst_busy", o_busy, 1'b0); chk("post_rst_mflo", o_pc, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) != 0);
      id_instruction     = ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      id_ex_instruction  = ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      ex_mem_instruction = ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      id_ex_gpr_w_sel  = 2'($urandom_range(0, 3));
      ex_mem_gpr_w_sel = 2'($urandom_range(0, 3));
      id_ex_mem_read   = 1'($urandom_range(0, 1));
      ex_mem_mem_read  = 1'($urandom_range(0, 1));
      id_uses_rs       = 1'($urandom_range(0, 1));
      id_uses_rt       = 1'($urandom_range(0, 1));
      id_is_branch     = ($urandom_range(0, 3) == 0);
      id_branch_taken  = 1'($urandom_range(0, 1));
      id_is_md         = ($urandom_range(0, 7) == 0);
      id_md_is_div     = ($urandom_range(0, 3) == 0);
      id_reads_hilo    = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
